// File: rtl/mem_access_pkg.sv
// Shared opcodes, funct3 codes, FSM states and small decode helpers for the
// RV32I memory stage.
package mem_access_pkg;

  // Major opcodes that the memory stage acts on.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Load funct3 codes.
  localparam logic [2:0] FUNC3_LB  = 3'd0;
  localparam logic [2:0] FUNC3_LH  = 3'd1;
  localparam logic [2:0] FUNC3_LW  = 3'd2;
  localparam logic [2:0] FUNC3_LBU = 3'd4;
  localparam logic [2:0] FUNC3_LHU = 3'd5;

  // Store funct3 codes.
  localparam logic [2:0] FUNC3_SB  = 3'd0;
  localparam logic [2:0] FUNC3_SH  = 3'd1;
  localparam logic [2:0] FUNC3_SW  = 3'd2;

  // Access FSM states.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  // Lane-replicated store data and its byte enables.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_lane_t;

  // True when funct3 names an access the core supports for this direction.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return f3 inside {FUNC3_SB, FUNC3_SH, FUNC3_SW};
    end
    return f3 inside {FUNC3_LB, FUNC3_LH, FUNC3_LW, FUNC3_LBU, FUNC3_LHU};
  endfunction

  // Size is funct3[1:0]: halves need an even address, words a 4-byte one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Replicate the store operand across the word and enable only its lanes.
  function automatic store_lane_t store_lanes(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] val2);
    store_lane_t s;
    s.wdata = val2;
    s.wstrb = 4'b1111;
    case (f3)
      FUNC3_SB: begin
        s.wdata = {4{val2[7:0]}};
        s.wstrb = 4'b0001 << off;
      end
      FUNC3_SH: begin
        s.wdata = {2{val2[15:0]}};
        s.wstrb = 4'b0011 << off;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load lane select plus sign/zero extension.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_x;
  logic signed [31:0] half_x;

  // Bring the addressed byte/half down to bit 0; words are always aligned.
  assign shifted = rdata >> {addr_lo, 3'b000};

  // Signed extension happens through signed-to-signed assignment.
  always_comb begin
    byte_s = shifted[7:0];
    half_s = shifted[15:0];
    byte_x = byte_s;
    half_x = half_s;
  end

  // Pick the extension that matches the load flavour.
  always_comb begin
    data = shifted;
    case (funct3)
      FUNC3_LB:  data = byte_x;
      FUNC3_LH:  data = half_x;
      FUNC3_LW:  data = shifted;
      FUNC3_LBU: data = {24'b0, shifted[7:0]};
      FUNC3_LHU: data = {16'b0, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid port, aligns
// byte lanes, extends load data and stalls upstream until the access retires.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        M_valid_i,
  input  logic [6:0]  M_opcode_i,
  input  logic [2:0]  M_funct3_i,
  input  logic [31:0] M_valE_i,
  input  logic [31:0] M_val2_i,
  output logic [31:0] m_valM_o,
  output logic        m_stall_o,
  output logic        m_done_o,
  output logic        m_fault_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  mem_state_e  state_q, state_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        legal_op;
  logic        accept;
  logic        load_cap;
  store_lane_t lanes;

  // Request held stable on the bus while the FSM sits in REQ.
  logic [31:0] addr_p1;
  logic [1:0]  off_p1;
  logic [2:0]  funct3_p1;
  logic        we_p1;
  logic [31:0] wdata_p1;
  logic [3:0]  wstrb_p1;

  // Registered, extended load result.
  logic [31:0] valm_p2;
  logic [31:0] ext_data;

  // ---- stage 0: decode of the incoming M-stage instruction ----
  assign is_load  = (M_opcode_i == OP_LOAD);
  assign is_store = (M_opcode_i == OP_STORE);
  assign is_mem   = M_valid_i & (is_load | is_store);
  assign legal_op = f3_legal(is_store, M_funct3_i) &
                    ~misaligned(M_funct3_i[1:0], M_valE_i[1:0]);
  assign lanes    = store_lanes(M_funct3_i, M_valE_i[1:0], M_val2_i);

  // Next-state and handshake outputs; stall/done/fault are combinational.
  always_comb begin
    state_d    = state_q;
    m_stall_o  = 1'b0;
    m_done_o   = 1'b0;
    m_fault_o  = 1'b0;
    dmem_req_o = 1'b0;
    accept     = 1'b0;
    load_cap   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (is_mem) begin
          if (legal_op) begin
            accept    = 1'b1;
            m_stall_o = 1'b1;
            state_d   = MEM_REQ;
          end else begin
            // Faulting ops never reach the bus and let the pipeline move on.
            m_fault_o = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        dmem_req_o = 1'b1;
        m_stall_o  = 1'b1;
        // An rvalid coinciding with gnt is not this access's data.
        if (dmem_gnt_i) begin
          state_d = we_p1 ? MEM_DONE : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        m_stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          load_cap = 1'b1;
          state_d  = MEM_DONE;
        end
      end
      MEM_DONE: begin
        // Pipeline advances on this edge, so the op cannot be reissued.
        m_done_o = 1'b1;
        state_d  = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- stage 1: request latch, captured once when an op is accepted ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_p1   <= '0;
      off_p1    <= '0;
      funct3_p1 <= '0;
      we_p1     <= 1'b0;
      wdata_p1  <= '0;
      wstrb_p1  <= '0;
    end else if (accept) begin
      addr_p1   <= {M_valE_i[31:2], 2'b00};
      off_p1    <= M_valE_i[1:0];
      funct3_p1 <= M_funct3_i;
      we_p1     <= is_store;
      wdata_p1  <= is_store ? lanes.wdata : '0;
      wstrb_p1  <= is_store ? lanes.wstrb : 4'b0000;
    end
  end

  assign dmem_we_o    = we_p1;
  assign dmem_addr_o  = addr_p1;
  assign dmem_wdata_o = wdata_p1;
  assign dmem_wstrb_o = wstrb_p1;

  // ---- stage 2: load data extension and result register ----
  mem_load_ext u_load_ext (
    .rdata   (dmem_rdata_i),
    .addr_lo (off_p1),
    .funct3  (funct3_p1),
    .data    (ext_data)
  );

  // Load result only changes when read data arrives in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valm_p2 <= '0;
    end else if (load_cap) begin
      valm_p2 <= ext_data;
    end
  end

  assign m_valM_o = valm_p2;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios followed by randomized ops, all
// checked against an arithmetic reference of the load/store rules.
module tb_mem_access;

  localparam logic [6:0] LOAD  = 7'h03;
  localparam logic [6:0] STORE = 7'h23;
  localparam logic [6:0] ALU   = 7'h33;

  logic        clk;
  logic        rst;
  logic        M_valid;
  logic [6:0]  M_opcode;
  logic [2:0]  M_funct3;
  logic [31:0] M_valE;
  logic [31:0] M_val2;
  logic [31:0] m_valM;
  logic        m_stall;
  logic        m_done;
  logic        m_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int          checks;
  int          failures;
  logic [31:0] exp_valm;

  mem_access dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .M_valid_i     (M_valid),
    .M_opcode_i    (M_opcode),
    .M_funct3_i    (M_funct3),
    .M_valE_i      (M_valE),
    .M_val2_i      (M_val2),
    .m_valM_o      (m_valM),
    .m_stall_o     (m_stall),
    .m_done_o      (m_done),
    .m_fault_o     (m_fault),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_wstrb_o  (dmem_wstrb),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] val2);
    logic [31:0] w;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = val2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] s;
    int off;
    int n;
    s = '0;
    off = int'(addr % 32'd4);
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
    return s;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint unsigned r;
    longint v;
    longint span;
    int off;
    int n;
    r = rdata;
    off = int'(addr % 32'd4);
    n = nbytes(f3);
    span = longint'(1) << (8 * n);
    v = longint'((r >> (8 * off)) % longint'(span));
    if (!f3[2] && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Drive one M-stage instruction and act as the memory for it.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] val2,
                       input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                       input bit rv_with_gnt, input bit valid);
    bit mem;
    bit st;
    bit ok;
    mem = valid && (op == LOAD || op == STORE);
    st  = (op == STORE);
    ok  = mem && is_legal(st, f3) && is_aligned(f3, addr);

    @(negedge clk);
    M_valid     = valid;
    M_opcode    = op;
    M_funct3    = f3;
    M_valE      = addr;
    M_val2      = val2;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    #1;
    chk("idle_stall", {31'b0, m_stall}, {31'b0, ok});
    chk("idle_fault", {31'b0, m_fault}, {31'b0, mem && !ok});
    chk("idle_req",   {31'b0, dmem_req}, 32'd0);
    chk("idle_done",  {31'b0, m_done}, 32'd0);

    if (!ok) begin
      @(negedge clk);
      M_valid     = 1'b0;
      dmem_rvalid = 1'b0;
      #1;
      chk("valm_hold", m_valM, exp_valm);
      chk("post_stall", {31'b0, m_stall}, 32'd0);
      return;
    end

    for (int k = 0; k <= gnt_dly; k++) begin
      @(negedge clk);
      dmem_gnt    = (k == gnt_dly);
      dmem_rvalid = rv_with_gnt && (k == gnt_dly);
      dmem_rdata  = $urandom;
      #1;
      chk("req_req",   {31'b0, dmem_req}, 32'd1);
      chk("req_we",    {31'b0, dmem_we}, {31'b0, st});
      chk("req_addr",  dmem_addr, {addr[31:2], 2'b00});
      chk("req_wstrb", {28'b0, dmem_wstrb}, st ? model_wstrb(f3, addr) : 32'd0);
      if (st) chk("req_wdata", dmem_wdata, model_wdata(f3, val2));
      chk("req_stall", {31'b0, m_stall}, 32'd1);
      chk("req_done",  {31'b0, m_done}, 32'd0);
    end

    if (!st) begin
      for (int k = 0; k <= rv_dly; k++) begin
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = (k == rv_dly);
        dmem_rdata  = dmem_rvalid ? rdata : $urandom;
        #1;
        chk("wait_stall", {31'b0, m_stall}, 32'd1);
        chk("wait_req",   {31'b0, dmem_req}, 32'd0);
        chk("wait_done",  {31'b0, m_done}, 32'd0);
      end
      exp_valm = model_load(f3, addr, rdata);
    end

    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    chk("done_done",  {31'b0, m_done}, 32'd1);
    chk("done_stall", {31'b0, m_stall}, 32'd0);
    chk("done_req",   {31'b0, dmem_req}, 32'd0);
    chk("done_valm",  m_valM, exp_valm);

    @(negedge clk);
    M_valid = 1'b0;
    #1;
    chk("after_done",  {31'b0, m_done}, 32'd0);
    chk("after_stall", {31'b0, m_stall}, 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_valm    = '0;
    rst         = 1'b1;
    M_valid     = 1'b0;
    M_opcode    = '0;
    M_funct3    = '0;
    M_valE      = '0;
    M_val2      = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valm",  m_valM, 32'd0);
    chk("rst_stall", {31'b0, m_stall}, 32'd0);
    chk("rst_done",  {31'b0, m_done}, 32'd0);
    chk("rst_fault", {31'b0, m_fault}, 32'd0);
    chk("rst_req",   {31'b0, dmem_req}, 32'd0);
    chk("rst_we",    {31'b0, dmem_we}, 32'd0);
    chk("rst_addr",  dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
    rst = 1'b0;

    // Directed scenarios.
    do_op(STORE, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b1);
    do_op(STORE, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 1'b1);
    do_op(LOAD,  3'd0, 32'h0000_0102, 32'h0,         32'h0080_FF00, 0, 2, 1'b0, 1'b1);
    chk("lb_value", m_valM, 32'hFFFF_FF80);
    do_op(LOAD,  3'd4, 32'h0000_0102, 32'h0,         32'h0080_FF00, 0, 2, 1'b0, 1'b1);
    chk("lbu_value", m_valM, 32'h0000_0080);
    do_op(LOAD,  3'd1, 32'h0000_0101, 32'h0,         32'h1234_5678, 0, 0, 1'b0, 1'b1);
    do_op(STORE, 3'd1, 32'h0000_0202, 32'h0000_C3D4, 32'h0, 5, 0, 1'b0, 1'b1);
    do_op(LOAD,  3'd5, 32'h0000_0302, 32'h0,         32'h8765_4321, 1, 1, 1'b1, 1'b1);
    do_op(LOAD,  3'd1, 32'h0000_0302, 32'h0,         32'h8765_4321, 0, 0, 1'b0, 1'b1);
    do_op(LOAD,  3'd2, 32'h0000_0404, 32'h0,         32'hCAFE_F00D, 2, 0, 1'b0, 1'b1);
    do_op(LOAD,  3'd3, 32'h0000_0400, 32'h0,         32'h0, 0, 0, 1'b0, 1'b1);
    do_op(STORE, 3'd4, 32'h0000_0400, 32'h1,         32'h0, 0, 0, 1'b0, 1'b1);
    do_op(STORE, 3'd2, 32'h0000_0402, 32'h1,         32'h0, 0, 0, 1'b0, 1'b1);
    do_op(ALU,   3'd2, 32'h0000_0400, 32'h1,         32'h0, 0, 0, 1'b0, 1'b1);
    do_op(LOAD,  3'd2, 32'h0000_0400, 32'h1,         32'h0, 0, 0, 1'b0, 1'b0);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    M_valid  = 1'b1;
    M_opcode = LOAD;
    M_funct3 = 3'd2;
    M_valE   = 32'h0000_0200;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    M_valid  = 1'b0;
    #1;
    chk("wait_before_rst", {31'b0, m_stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    exp_valm    = '0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    #1;
    chk("rst_mid_req",   {31'b0, dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, m_stall}, 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("rst_mid_done", {31'b0, m_done}, 32'd0);
    chk("rst_mid_valm", m_valM, 32'd0);
    do_op(LOAD, 3'd0, 32'h0000_0201, 32'h0, 32'h0000_7F00, 0, 0, 1'b0, 1'b1);

    // Randomized ops.
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0, 1:    op = LOAD;
        2:       op = STORE;
        default: op = ALU;
      endcase
      do_op(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
